// File: rtl/fifo_mem.sv
// Simple dual-port storage for the FIFO: unreset array, one write port,
// and one registered read port whose register clears on reset.
module fifo_mem #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              wr_en_i,
    input  logic [AWIDTH-1:0] wr_addr_i,
    input  logic [DWIDTH-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [AWIDTH-1:0] rd_addr_i,
    output logic [DWIDTH-1:0] rd_data_o
);

    localparam int DEPTH = 2 ** AWIDTH;

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [DWIDTH-1:0] r_rd_data;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            r_mem[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_rd_data <= '0;
        end else if (rd_en_i) begin
            r_rd_data <= r_mem[rd_addr_i];
        end
    end

    assign rd_data_o = r_rd_data;

endmodule

// File: rtl/fifo.sv
// Single-clock circular FIFO with registered occupancy count and
// full/empty/almost flags, all derived from the next occupancy value.
module fifo #(
    parameter int DWIDTH       = 16,
    parameter int AWIDTH       = 8,
    parameter int ALMOST_FULL  = 2,
    parameter int ALMOST_EMPTY = 2
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              wrreq_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              rdreq_i,
    output logic [DWIDTH-1:0] q_o,
    output logic              almost_empty_o,
    output logic              empty_o,
    output logic              almost_full_o,
    output logic              full_o,
    output logic [AWIDTH:0]   usedw_o
);

    localparam int DEPTH = 2 ** AWIDTH;
    localparam int UW    = AWIDTH + 1;

    localparam logic [AWIDTH:0] LP_DEPTH = UW'(DEPTH);
    localparam logic [AWIDTH:0] LP_AF    = UW'(DEPTH - ALMOST_FULL);
    localparam logic [AWIDTH:0] LP_AE    = UW'(ALMOST_EMPTY);

    logic [AWIDTH-1:0] r_wr_ptr;
    logic [AWIDTH-1:0] r_rd_ptr;
    logic [AWIDTH:0]   r_usedw;
    logic              r_empty;
    logic              r_full;
    logic              r_aempty;
    logic              r_afull;

    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [AWIDTH:0]   w_usedw_nxt;

    // Acceptance looks only at the registered flags from before the edge.
    assign w_wr_acc = wrreq_i && !r_full;
    assign w_rd_acc = rdreq_i && !r_empty;

    always_comb begin
        w_usedw_nxt = r_usedw;
        unique case ({w_wr_acc, w_rd_acc})
            2'b10:   w_usedw_nxt = r_usedw + UW'(1);
            2'b01:   w_usedw_nxt = r_usedw - UW'(1);
            default: w_usedw_nxt = r_usedw;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_usedw  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_aempty <= 1'b1;
            r_afull  <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AWIDTH'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + AWIDTH'(1);
            end
            r_usedw  <= w_usedw_nxt;
            r_empty  <= (w_usedw_nxt == '0);
            r_full   <= (w_usedw_nxt == LP_DEPTH);
            r_aempty <= (w_usedw_nxt <= LP_AE);
            r_afull  <= (w_usedw_nxt >= LP_AF);
        end
    end

    fifo_mem #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_mem (
        .clk_i     (clk_i),
        .arstn_i   (arstn_i),
        .wr_en_i   (w_wr_acc),
        .wr_addr_i (r_wr_ptr),
        .wr_data_i (data_i),
        .rd_en_i   (w_rd_acc),
        .rd_addr_i (r_rd_ptr),
        .rd_data_o (q_o)
    );

    assign usedw_o        = r_usedw;
    assign empty_o        = r_empty;
    assign full_o         = r_full;
    assign almost_empty_o = r_aempty;
    assign almost_full_o  = r_afull;

endmodule

// File: tb/tb_fifo.sv
// Randomized directed bench for fifo against a queue-based reference.
// Every cycle compares all outputs with the model's view of occupancy.
module tb_fifo;

    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic          clk;
    logic          arstn;
    logic          wrreq;
    logic          rdreq;
    logic [DW-1:0] data;
    logic [DW-1:0] q;
    logic          aempty;
    logic          empty;
    logic          afull;
    logic          full;
    logic [AW:0]   usedw;

    int n_checks;
    int n_pass;

    logic [DW-1:0] m_fifo[$];
    logic [DW-1:0] m_q;

    fifo #(
        .DWIDTH       (DW),
        .AWIDTH       (AW),
        .ALMOST_FULL  (2),
        .ALMOST_EMPTY (2)
    ) dut (
        .clk_i          (clk),
        .arstn_i        (arstn),
        .wrreq_i        (wrreq),
        .data_i         (data),
        .rdreq_i        (rdreq),
        .q_o            (q),
        .almost_empty_o (aempty),
        .empty_o        (empty),
        .almost_full_o  (afull),
        .full_o         (full),
        .usedw_o        (usedw)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h at %0t",
                    tag, obs, exp, $time);
    endtask

    task automatic check_outs(input string tag);
        int sz;
        sz = m_fifo.size();
        chk({tag, ".usedw"}, 32'(usedw), 32'(sz));
        chk({tag, ".empty"}, 32'(empty), 32'(sz == 0));
        chk({tag, ".full"}, 32'(full), 32'(sz == DEPTH));
        chk({tag, ".aempty"}, 32'(aempty), 32'(sz <= 2));
        chk({tag, ".afull"}, 32'(afull), 32'(sz >= DEPTH - 2));
        chk({tag, ".q"}, 32'(q), 32'(m_q));
    endtask

    task automatic cyc(input string tag, input logic wr, input logic rd,
                       input logic [DW-1:0] d);
        logic wacc;
        logic racc;
        @(negedge clk);
        wrreq = wr;
        rdreq = rd;
        data  = d;
        @(posedge clk);
        wacc = wr && (m_fifo.size() < DEPTH);
        racc = rd && (m_fifo.size() > 0);
        if (racc) m_q = m_fifo.pop_front();
        if (wacc) m_fifo.push_back(d);
        #1;
        check_outs(tag);
    endtask

    initial begin
        logic [DW-1:0] w;
        n_checks = 0;
        n_pass   = 0;
        m_q      = '0;
        arstn    = 1'b1;
        wrreq    = 1'b0;
        rdreq    = 1'b0;
        data     = '0;

        #1 arstn = 1'b0;
        #1 check_outs("reset");
        @(negedge clk);
        @(negedge clk);
        arstn = 1'b1;

        for (int i = 0; i < DEPTH; i++) cyc("fill", 1'b1, 1'b0, DW'($urandom));
        chk("fill.full256", 32'(full), 32'd1);
        cyc("overfill", 1'b1, 1'b0, DW'($urandom));
        for (int i = 0; i < DEPTH; i++) cyc("drain", 1'b0, 1'b1, '0);
        chk("drain.empty", 32'(empty), 32'd1);

        for (int i = 0; i < 3; i++) cyc("rd_empty", 1'b0, 1'b1, '0);

        for (int i = 0; i < DEPTH; i++) cyc("fill2", 1'b1, 1'b0, DW'($urandom));
        cyc("both_full", 1'b1, 1'b1, 16'hdead);
        chk("both_full.usedw", 32'(usedw), 32'd255);
        for (int i = 0; i < DEPTH - 1; i++) cyc("drain2", 1'b0, 1'b1, '0);

        w = DW'($urandom);
        cyc("both_empty", 1'b1, 1'b1, w);
        chk("both_empty.usedw", 32'(usedw), 32'd1);
        cyc("after_empty", 1'b0, 1'b1, '0);
        chk("after_empty.q", 32'(q), 32'(w));

        for (int i = 0; i < 10; i++) cyc("preload", 1'b1, 1'b0, DW'($urandom));
        for (int i = 0; i < 600; i++) cyc("stream", 1'b1, 1'b1, DW'($urandom));
        chk("stream.usedw", 32'(usedw), 32'd10);
        for (int i = 0; i < 10; i++) cyc("drain3", 1'b0, 1'b1, '0);

        for (int i = 0; i < 100; i++) cyc("pre_rst", 1'b1, 1'b0, DW'($urandom));
        cyc("pre_rst_rd", 1'b0, 1'b1, '0);
        @(negedge clk);
        #2 arstn = 1'b0;
        m_fifo.delete();
        m_q = '0;
        #1 check_outs("async_rst");
        @(negedge clk);
        arstn = 1'b1;
        w = DW'($urandom);
        cyc("post_wr", 1'b1, 1'b0, w);
        cyc("post_rd", 1'b0, 1'b1, '0);
        chk("post_rd.q", 32'(q), 32'(w));
        cyc("idle", 1'b0, 1'b0, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
